// File: rtl/if_fetch_unit.sv
// Fetch stage and PC generator feeding the IF/ID register.
// Synchronous imem with one-cycle read latency; stall/redirect aware.
module if_fetch_unit #(
  parameter int              PC_W     = 12,
  parameter int              INSTR_W  = 32,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = 12'h000,
  parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    IF_PC,
  output logic [INSTR_W-1:0] IF_Instruction,
  output logic               IF_valid
);

  localparam logic [PC_W-1:0] STEP  = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;

  logic [PC_W-1:0] tgt;
  logic m_sbr, m_hold, m_br, m_run;

  assign tgt    = branch_target & ALIGN;
  assign m_sbr  = stall & branch_taken;
  assign m_hold = stall & ~branch_taken;
  assign m_br   = ~stall & branch_taken;
  assign m_run  = ~stall & ~branch_taken;

  // Re-read the in-flight address while stalled so data stays aligned.
  assign imem_addr = stall ? req_pc_q : fetch_pc_q;

  assign IF_PC          = if_pc_q;
  assign IF_Instruction = if_instr_q;
  assign IF_valid       = if_valid_q;

  // Next-state: hold, advance, redirect, or redirect under stall.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    unique case (1'b1)
      m_sbr: begin
        fetch_pc_d  = tgt;
        req_valid_d = 1'b0;
      end
      m_hold: begin
      end
      m_br: begin
        if_pc_d     = req_pc_q;
        if_instr_d  = req_valid_q ? imem_rdata : NOP_WORD;
        if_valid_d  = req_valid_q;
        req_pc_d    = fetch_pc_q;
        req_valid_d = 1'b0;
        fetch_pc_d  = tgt;
      end
      m_run: begin
        if_pc_d     = req_pc_q;
        if_instr_d  = req_valid_q ? imem_rdata : NOP_WORD;
        if_valid_d  = req_valid_q;
        req_pc_d    = fetch_pc_q;
        req_valid_d = 1'b1;
        fetch_pc_d  = fetch_pc_q + STEP;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset aborts any in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= NOP_WORD;
      if_valid_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic
// checked against an output-stream model (next PC + owed bubbles).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] m_next;
  int          m_bub;
  logic [11:0] e_pc;
  logic [31:0] e_ins;
  logic        e_val;
  logic        e_pc_known;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .IF_PC          (IF_PC),
    .IF_Instruction (IF_Instruction),
    .IF_valid       (IF_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [11:0] a);
    return 32'hA000_0000 + {20'b0, a};
  endfunction

  // One-cycle synchronous instruction memory.
  always @(posedge clk) imem_rdata <= memw(imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic b, input logic [11:0] t);
    logic [11:0] tg;
    @(negedge clk);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    tg = t & 12'hFFC;
    #1;
    if (!r && m_bub == 0) begin
      if (s) chk("addr_stall", {20'b0, imem_addr}, {20'b0, m_next});
      else   chk("addr_run", {20'b0, imem_addr},
                 {20'b0, m_next + 12'd4});
    end
    @(posedge clk);
    if (r) begin
      e_val = 1'b0; e_ins = 32'h0; e_pc = 12'h0; e_pc_known = 1'b1;
      m_next = 12'h000; m_bub = 1;
    end else if (s) begin
      if (b) begin
        m_next = tg; m_bub = 1;
      end
    end else begin
      if (m_bub > 0) begin
        e_val = 1'b0; e_ins = 32'h0; e_pc_known = 1'b0;
        m_bub--;
      end else begin
        e_val = 1'b1; e_pc = m_next; e_ins = memw(m_next);
        e_pc_known = 1'b1;
        m_next = m_next + 12'd4;
      end
      if (b) begin
        m_next = tg; m_bub = 1;
      end
    end
    #1;
    chk("valid", {31'b0, IF_valid}, {31'b0, e_val});
    chk("instr", IF_Instruction, e_ins);
    if (e_pc_known) chk("pc", {20'b0, IF_PC}, {20'b0, e_pc});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 12'h0;
    m_next = 12'h0; m_bub = 1;
    e_pc = 12'h0; e_ins = 32'h0; e_val = 1'b0; e_pc_known = 1'b0;
    m_bub = 99;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Fill: bubble, 0x000, 0x004, 0x008
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    // Stall three cycles holding 0x008
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
    // Redirect to misaligned 0x103
    cyc(0, 0, 1, 12'h103);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    // Redirect under stall
    cyc(0, 1, 1, 12'h200);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    // Wrap-around
    cyc(0, 0, 1, 12'hFF8);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    // Back-to-back redirects
    cyc(0, 0, 1, 12'h040);
    cyc(0, 0, 1, 12'h080);
    cyc(0, 0, 1, 12'h0C0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    // Reset mid-stream with stall active
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, b;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 15);
      cyc(r, s, b, 12'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch stage and PC generator that produces the IF_PC / IF_Instruction pair consumed by the IF/ID pipeline register.
- Issues addresses to a synchronous instruction memory with 1-cycle read latency and registers the returned word with its PC.
- Handles hazard stalls by holding its state, and branch redirects by loading a new PC and squashing the wrong-path fetch into a NOP bubble.

Parameters:
- PC_W, 12, PC / instruction-address width in bits.
- INSTR_W, 32, instruction width in bits.
- PC_STEP, 4, byte increment between sequential fetches.
- RESET_PC, 12'h000, first fetch address after reset.
- NOP_WORD, 32'h0000_0000, encoding emitted for squashed or empty slots.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  1 = hold fetch state and outputs (from hazard unit).
- branch_taken  in  1  1 = redirect fetch to branch_target this cycle.
- branch_target  in  PC_W  redirect address; bits [1:0] ignored (forced to 0).
- imem_addr  out  PC_W  instruction memory read address (combinational).
- imem_rdata  in  INSTR_W  memory data for the address presented on the previous edge.
- IF_PC  out  PC_W  PC of IF_Instruction.
- IF_Instruction  out  INSTR_W  fetched instruction, or NOP_WORD when invalid.
- IF_valid  out  1  1 = IF_Instruction is a real, non-squashed fetch.

Behaviour:
- Internal registers:
  - fetch_pc: next address to issue.
  - req_pc: address issued on the previous edge.
  - req_valid: whether the word now on imem_rdata is to be used.
- imem_addr = stall ? req_pc : fetch_pc. During a stall the in-flight address is re-read, so imem_rdata still matches req_pc when the stall releases.
- Reset (rst=1 at posedge), highest priority, aborts any in-flight fetch:
  - fetch_pc=RESET_PC, req_pc=RESET_PC, req_valid=0.
  - IF_PC=0, IF_Instruction=NOP_WORD, IF_valid=0.
- Normal cycle (stall=0, branch_taken=0):
  - IF_PC<=req_pc; IF_Instruction<=req_valid ? imem_rdata : NOP_WORD; IF_valid<=req_valid.
  - req_pc<=fetch_pc; req_valid<=1; fetch_pc<=fetch_pc+PC_STEP.
- Redirect (branch_taken=1, stall=0):
  - Outputs update as in a normal cycle.
  - req_pc<=fetch_pc; req_valid<=0 (wrong-path fetch squashed).
  - fetch_pc<={branch_target[PC_W-1:2],2'b00}.
- Stall (stall=1, branch_taken=0): every register holds, including all outputs.
- Stall with redirect (both 1):
  - Redirect has priority over stall for fetch state: fetch_pc<=aligned target, req_valid<=0.
  - Outputs and req_pc hold.
  - First unstalled cycle outputs a NOP bubble.
- State view (derived from req_valid/reset, no extra encoding needed):
  - FILL: first cycle after reset.
  - RUN.
  - SQUASH: cycle after a redirect.
  - FILL->RUN and SQUASH->RUN on any unstalled cycle without branch_taken.
  - Any state ->SQUASH on branch_taken.
- Latency:
  - Reset release to first IF_valid=1 is 2 unstalled edges.
  - Redirect to first target instruction on outputs is 2 unstalled edges, with exactly 1 bubble between.
- Wrap-around: fetch_pc+PC_STEP is mod 2^PC_W (0xFFC -> 0x000, no flag).
- Back-to-back branch_taken: each squashes the previous redirect's fetch; the last target wins.

Test Plan:
- Reset, then release with mem[n]=32'hA000_0000+n: IF_valid=0 on edge 1. Edge 2 gives IF_PC=0x000 / 32'hA000_0000. Edge 3 gives IF_PC=0x004 / 32'hA000_0004, valid=1.
- Stall held 3 cycles while IF_PC=0x008: outputs frozen for 3 edges and imem_addr=0x00C throughout. After release, next output is IF_PC=0x00C with its correct word; no duplicate and no skip.
- branch_taken=1, target=0x103 while fetch_pc=0x010: one bubble (IF_valid=0, NOP_WORD). Then IF_PC=0x100 with mem[0x100], then 0x104.
- stall=1 and branch_taken=1 together, target=0x200, then stall released: outputs hold during the stall. First released edge gives a bubble, then IF_PC=0x200.
- Wrap: branch to 0xFF8 runs 0xFF8, 0xFFC, 0x000, 0x004 with IF_valid=1 each.
- rst asserted mid-stream with the pipeline full and a stall active: next edge gives IF_valid=0, IF_PC=0, IF_Instruction=NOP_WORD. The sequence restarts at RESET_PC exactly as in the first scenario.
